// File: rtl/usb_bulk_in_fifo_pkg.sv
// Shared USB definitions for the transfer blocks.
// Holds the high-speed and full-speed bulk max-packet sizes and the
// layout of one buffered FIFO entry.
package usb_bulk_in_fifo_pkg;

  localparam int unsigned USB_HS_MAX_PACKET = 512;
  localparam int unsigned USB_FS_MAX_PACKET = 64;
  localparam int unsigned USB_BYTE_W        = 8;

  // One buffered byte plus its end-of-packet marker.
  typedef struct packed {
    logic                  last;
    logic [USB_BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/usb_fifo_ram.sv
// Simple dual-port RAM with one write port and one read port.
// The read data is registered: it appears one cycle after re_i.
// The output register keeps its value on cycles when re_i is low.
// Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable; waddr_i / wdata_i give the address and data
//   re_i    : read enable; raddr_i gives the address
//   rdata_o : registered read data
module usb_fifo_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_bulk_in_fifo.sv
// Packet FIFO that sits between user logic and the USB bulk-IN endpoint.
// Bytes arrive on an AXI4-Stream slave and are held in a circular buffer.
// A byte becomes visible on the bid side only after its packet has been
// completed, either by s_tlast or by reaching MAX_PACKET bytes.
//   clk, rst_n                 : clock; asynchronous active-low reset
//   s_tvalid/s_tready/s_tlast/s_tdata : user write stream
//   bid_tvalid_o/bid_tready_i/bid_tlast_o/bid_tdata_o : endpoint read stream
//   bid_has_data_o             : at least one complete packet is buffered
//   level_o                    : bytes stored, including the output register
//   pkt_count_o                : complete packets stored
module usb_bulk_in_fifo
  import usb_bulk_in_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned MAX_PACKET = USB_HS_MAX_PACKET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [7:0]          s_tdata,
  output logic                bid_has_data_o,
  output logic                bid_tvalid_o,
  input  logic                bid_tready_i,
  output logic                bid_tlast_o,
  output logic [7:0]          bid_tdata_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic [DEPTH_LOG2:0] pkt_count_o
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PACKET - 1);

  // wr_ptr: next free slot; commit_ptr: end of the last complete packet;
  // rd_ptr: next slot to fetch from RAM; free_ptr: oldest slot still owned
  // (fetched bytes keep their slot until they leave through the bid port).
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    free_ptr_q, free_ptr_d;
  logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             out_valid_q, out_valid_d;
  fifo_entry_t      out_entry_q, out_entry_d;
  logic             s_tready_q, s_tready_d;
  logic             has_data_q, has_data_d;

  logic             wr_fire;
  logic             last_in;
  logic             pop;
  logic             load;
  logic             re;
  logic             avail;
  logic [PW-1:0]    level_d;
  fifo_entry_t      ram_wdata;
  fifo_entry_t      ram_rdata;

  usb_fifo_ram #(
    .AW(DEPTH_LOG2),
    .DW($bits(fifo_entry_t))
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_fire),
    .waddr_i(wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i(ram_wdata),
    .re_i   (re),
    .raddr_i(rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    wr_fire   = s_tvalid && s_tready_q;
    last_in   = s_tlast || (byte_cnt_q == CNT_LAST);
    ram_wdata = '{last: last_in, data: s_tdata};
    pop       = out_valid_q && bid_tready_i;
    avail     = (commit_ptr_q != rd_ptr_q);
    // The RAM read register doubles as a skid stage: a fetched byte waits
    // there (rd_pend) until the output register can take it, and no new
    // read is issued that would overwrite it.
    load      = rd_pend_q && (!out_valid_q || bid_tready_i);
    re        = avail && (!rd_pend_q || load);

    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (last_in) begin
        commit_ptr_d = wr_ptr_q + PW'(1);
        byte_cnt_d   = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end

    rd_ptr_d   = re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    free_ptr_d = pop ? free_ptr_q + PW'(1) : free_ptr_q;

    rd_pend_d = rd_pend_q;
    if (re)        rd_pend_d = 1'b1;
    else if (load) rd_pend_d = 1'b0;

    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_entry_d = ram_rdata;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    case ({wr_fire && last_in, pop && out_entry_q.last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    has_data_d = (pkt_cnt_d != '0);

    // Level never exceeds the buffer size, so its MSB alone flags full.
    level_d    = wr_ptr_d - free_ptr_d;
    s_tready_d = ~level_d[PW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      free_ptr_q   <= '0;
      pkt_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      s_tready_q   <= 1'b0;
      has_data_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      free_ptr_q   <= free_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_pend_q    <= rd_pend_d;
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      s_tready_q   <= s_tready_d;
      has_data_q   <= has_data_d;
    end
  end

  assign s_tready       = s_tready_q;
  assign bid_tvalid_o   = out_valid_q;
  assign bid_tlast_o    = out_entry_q.last;
  assign bid_tdata_o    = out_entry_q.data;
  assign bid_has_data_o = has_data_q;
  assign level_o        = wr_ptr_q - free_ptr_q;
  assign pkt_count_o    = pkt_cnt_q;

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Testbench for usb_bulk_in_fifo: a default-size instance and a small
// instance (16 bytes, 8-byte packets), checked by a scoreboard.
module tb_usb_bulk_in_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance (DEPTH_LOG2=11, MAX_PACKET=512)
  logic        b_tvalid = 1'b0, b_tready, b_tlast = 1'b0;
  logic [7:0]  b_tdata = 8'h00;
  logic        b_has, b_ovalid, b_oready = 1'b0, b_olast;
  logic [7:0]  b_odata;
  logic [11:0] b_level, b_pkt;

  // small instance (DEPTH_LOG2=4, MAX_PACKET=8)
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_has, s_ovalid, s_oready = 1'b0, s_olast;
  logic [7:0]  s_odata;
  logic [4:0]  s_level, s_pkt;

  usb_bulk_in_fifo dut_big (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tlast(b_tlast), .s_tdata(b_tdata),
    .bid_has_data_o(b_has), .bid_tvalid_o(b_ovalid), .bid_tready_i(b_oready),
    .bid_tlast_o(b_olast), .bid_tdata_o(b_odata),
    .level_o(b_level), .pkt_count_o(b_pkt)
  );

  usb_bulk_in_fifo #(.DEPTH_LOG2(4), .MAX_PACKET(8)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .bid_has_data_o(s_has), .bid_tvalid_o(s_ovalid), .bid_tready_i(s_oready),
    .bid_tlast_o(s_olast), .bid_tdata_o(s_odata),
    .level_o(s_level), .pkt_count_o(s_pkt)
  );

  int total = 0;
  int bad = 0;
  logic [8:0] exp_b[$];
  logic [8:0] exp_s[$];
  int mcnt_b = 0, mcnt_s = 0;
  int outn_b = 0, outn_s = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Input side: every accepted byte pushes its expected output entry;
  // the last flag is recomputed here from the bench's own byte counter.
  always @(negedge clk) begin : mon_in_b
    logic l;
    if (rst_n && b_tvalid && b_tready) begin
      l = b_tlast || (mcnt_b == 511);
      exp_b.push_back({l, b_tdata});
      mcnt_b = l ? 0 : mcnt_b + 1;
    end
  end

  always @(negedge clk) begin : mon_in_s
    logic l;
    if (rst_n && s_tvalid && s_tready) begin
      l = s_tlast || (mcnt_s == 7);
      exp_s.push_back({l, s_tdata});
      mcnt_s = l ? 0 : mcnt_s + 1;
    end
  end

  // Reset throws away everything buffered, committed or not.
  always @(negedge rst_n) begin
    exp_b.delete();
    exp_s.delete();
    mcnt_b = 0;
    mcnt_s = 0;
  end

  always @(negedge clk) begin : mon_out_b
    logic [8:0] e;
    if (rst_n && b_ovalid && b_oready) begin
      outn_b++;
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL big_extra_byte: got 0x%0h want no byte", {b_olast, b_odata});
      end else begin
        e = exp_b.pop_front();
        check("big_out_byte", {b_olast, b_odata}, e);
      end
    end
  end

  always @(negedge clk) begin : mon_out_s
    logic [8:0] e;
    if (rst_n && s_ovalid && s_oready) begin
      outn_s++;
      if (exp_s.size() == 0) begin
        total++; bad++;
        $display("FAIL small_extra_byte: got 0x%0h want no byte", {s_olast, s_odata});
      end else begin
        e = exp_s.pop_front();
        check("small_out_byte", {s_olast, s_odata}, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one byte and returns 1 time unit after the accepting edge.
  task automatic wr(input bit sm, input logic [7:0] d, input logic l);
    bit hs = 1'b0;
    if (sm) begin s_tvalid = 1'b1; s_tdata = d; s_tlast = l; end
    else    begin b_tvalid = 1'b1; b_tdata = d; b_tlast = l; end
    for (int t = 0; t < 400 && !hs; t++) begin
      @(negedge clk);
      hs = sm ? s_tready : b_tready;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      total++; bad++;
      $display("FAIL write_timeout: got tready=0 want tready=1 (byte 0x%0h)", d);
    end
    if (sm) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
    else    begin b_tvalid = 1'b0; b_tlast = 1'b0; end
  endtask

  task automatic wait_out(input bit sm, input int n, input string name);
    for (int t = 0; t < 5000 && (sm ? outn_s : outn_b) < n; t++) tick(1);
    check(name, sm ? outn_s : outn_b, n);
  endtask

  bit         done = 1'b0;
  int         nbytes = 0;
  logic [7:0] dd = 8'h00;

  initial begin
    // reset values
    rst_n = 1'b0;
    tick(3);
    check("rst_b_tready", b_tready, 0);
    check("rst_b_tvalid", b_ovalid, 0);
    check("rst_b_tlast", b_olast, 0);
    check("rst_b_tdata", b_odata, 0);
    check("rst_b_has", b_has, 0);
    check("rst_b_level", b_level, 0);
    check("rst_b_pkt", b_pkt, 0);
    check("rst_s_tready", s_tready, 0);
    rst_n = 1'b1;
    tick(1);
    check("rel_b_tready", b_tready, 1);
    check("rel_s_tready", s_tready, 1);

    // 10-byte packet: latency, throughput, counters
    b_oready = 1'b1;
    for (int i = 0; i < 10; i++) wr(1'b0, 8'(i), i == 9);
    check("t1_pkt", b_pkt, 1);
    check("t1_has", b_has, 1);
    check("t1_level", b_level, 10);
    check("t1_lat0", b_ovalid, 0);
    tick(1);
    check("t1_lat1", b_ovalid, 0);
    tick(1);
    check("t1_lat2", b_ovalid, 1);
    tick(10);
    check("t1_rate", outn_b, 10);
    check("t1_idle", b_ovalid, 0);
    check("t1_pkt_end", b_pkt, 0);
    check("t1_has_end", b_has, 0);
    check("t1_level_end", b_level, 0);

    // 600 bytes without tlast: 512 forced, 88 held back
    b_oready = 1'b0;
    for (int i = 0; i < 600; i++) wr(1'b0, 8'(i + 3), 1'b0);
    tick(3);
    check("t2_pkt", b_pkt, 1);
    check("t2_has", b_has, 1);
    check("t2_level", b_level, 600);
    check("t2_hold_valid", b_ovalid, 1);
    check("t2_hold_data", b_odata, 3);
    check("t2_hold_last", b_olast, 0);
    b_oready = 1'b1;
    wait_out(1'b0, 522, "t2_first_pkt");
    tick(20);
    check("t2_no_partial", outn_b, 522);
    check("t2_idle", b_ovalid, 0);
    check("t2_pkt_end", b_pkt, 0);
    check("t2_has_end", b_has, 0);
    check("t2_level_rest", b_level, 88);
    wr(1'b0, 8'hEE, 1'b1);
    wait_out(1'b0, 611, "t2_tail");
    tick(2);
    check("t2_level_end", b_level, 0);

    // small instance: fill to 16, one read frees a slot
    s_oready = 1'b0;
    for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h40 + i), (i % 4) == 3);
    check("t3_full_ready", s_tready, 0);
    check("t3_full_level", s_level, 16);
    check("t3_full_pkt", s_pkt, 4);
    check("t3_full_has", s_has, 1);
    s_oready = 1'b1;
    tick(1);
    s_oready = 1'b0;
    check("t3_ready_back", s_tready, 1);
    check("t3_level_15", s_level, 15);
    check("t3_one_read", outn_s, 1);
    s_oready = 1'b1;
    wait_out(1'b1, 16, "t3_drain");
    tick(2);
    check("t3_level_end", s_level, 0);
    check("t3_pkt_end", s_pkt, 0);

    // packet A ends on input while packet B ends on output
    s_oready = 1'b0;
    wr(1'b1, 8'h50, 1'b0);
    wr(1'b1, 8'h51, 1'b1);
    tick(4);
    check("t4_pre_pkt", s_pkt, 1);
    check("t4_pre_level", s_level, 2);
    s_tvalid = 1'b1; s_tdata = 8'h60; s_tlast = 1'b0; s_oready = 1'b1;
    tick(1);
    check("t4_mid_level", s_level, 2);
    s_tdata = 8'h61; s_tlast = 1'b1;
    tick(1);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_oready = 1'b0;
    check("t4_same_pkt", s_pkt, 1);
    check("t4_same_level", s_level, 2);
    check("t4_reads", outn_s, 18);
    s_oready = 1'b1;
    wait_out(1'b1, 20, "t4_drain");
    tick(2);
    check("t4_pkt_end", s_pkt, 0);

    // stream across many pointer wraps with irregular ready/valid
    s_oready = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          for (int k = 0; k < (p % 11) + 1; k++) begin
            if ((dd % 7) == 3) tick(1);
            wr(1'b1, dd, k == (p % 11));
            dd++;
            nbytes++;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          s_oready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
        s_oready = 1'b1;
      end
    join
    wait_out(1'b1, 20 + nbytes, "t5_stream");
    tick(3);
    check("t5_level_end", s_level, 0);
    check("t5_pkt_end", s_pkt, 0);
    check("t5_queue_empty", exp_s.size(), 0);

    // reset in the middle of a packet
    b_oready = 1'b0;
    wr(1'b0, 8'h11, 1'b0);
    wr(1'b0, 8'h12, 1'b1);
    wr(1'b0, 8'h13, 1'b0);
    wr(1'b0, 8'h14, 1'b0);
    tick(3);
    check("t6_pre_valid", b_ovalid, 1);
    check("t6_pre_level", b_level, 4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tready", b_tready, 0);
    check("t6_rst_tvalid", b_ovalid, 0);
    check("t6_rst_tlast", b_olast, 0);
    check("t6_rst_tdata", b_odata, 0);
    check("t6_rst_has", b_has, 0);
    check("t6_rst_level", b_level, 0);
    check("t6_rst_pkt", b_pkt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t6_rel_tready", b_tready, 1);
    b_oready = 1'b1;
    wr(1'b0, 8'hA0, 1'b0);
    wr(1'b0, 8'hA1, 1'b0);
    wr(1'b0, 8'hA2, 1'b1);
    wait_out(1'b0, outn_b + ((exp_b.size() == 3) ? 3 : 0) + ((exp_b.size() == 3) ? 0 : 3), "t6_after_rst");
    tick(2);
    check("t6_level_end", b_level, 0);
    check("t6_pkt_end", b_pkt, 0);
    check("t6_queue_empty", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_bulk_in_fifo.md
USB_BULK_IN_FIFO -- requirements
Module: usb_bulk_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 11, meaning buffer holds 2^DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter MAX_PACKET, default 512, meaning maximum bulk IN payload bytes per USB packet.
REQ-003 SHALL have port clk, input, 1, the single clock (60 MHz ULPI clock); all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports s_tvalid/s_tready/s_tlast, input/output/input, 1 each: user AXI4-Stream write side.
REQ-006 SHALL have port s_tdata, input, 8, user write byte.
REQ-007 SHALL have port bid_has_data_o, output, 1: at least one complete packet is buffered.
REQ-008 SHALL have ports bid_tvalid_o/bid_tready_i/bid_tlast_o, output/input/output, 1 each: read side to the USB bulk-IN endpoint.
REQ-009 SHALL have port bid_tdata_o, output, 8, read byte.
REQ-010 SHALL have port level_o, output, DEPTH_LOG2+1: bytes currently stored, including the output register.
REQ-011 SHALL have port pkt_count_o, output, DEPTH_LOG2+1: complete packets stored.

Function
REQ-012 SHALL store 9-bit entries {last, data} in a circular buffer with DEPTH_LOG2+1-bit write/read pointers; MSB distinguishes full from empty.
REQ-013 SHALL drive s_tready high iff stored bytes < 2^DEPTH_LOG2; a write occurs on s_tvalid && s_tready.
REQ-014 SHALL count bytes in the current input packet; the stored last bit is s_tlast OR (count == MAX_PACKET-1), and the count clears after any last-marked write.
REQ-015 SHALL increment pkt_count on each last-marked write and decrement it on each bid handshake with bid_tlast_o high; when both happen in one cycle, pkt_count is unchanged.
REQ-016 SHALL read only bytes belonging to complete packets; a partially written packet never reaches the bid port.
REQ-017 SHALL use a synchronous-read RAM plus a one-entry output register (prefetch); bid_tvalid_o asserts exactly 2 cycles after the committing last-marked write when the output register and buffer were empty.
REQ-018 SHALL sustain one byte per cycle on the bid port while data is committed (prefetch refills the output register on the same cycle it drains).
REQ-019 SHALL hold bid_tdata_o/bid_tlast_o stable while bid_tvalid_o && !bid_tready_i.
REQ-020 SHALL drive bid_has_data_o = (pkt_count != 0), registered.
REQ-021 SHALL allow simultaneous write and read with level_o unchanged.
REQ-022 SHALL wrap pointers modulo 2^(DEPTH_LOG2+1) without loss.
REQ-023 SHALL not support zero-length packets; a lone s_tlast byte forms a 1-byte packet.

Reset
REQ-024 SHALL, while rst_n is low, clear pointers, byte count, pkt_count, and the output register; reset takes effect asynchronously and is released synchronously to clk.
REQ-025 SHALL drive outputs during reset as: s_tready=0, bid_tvalid_o=0, bid_tlast_o=0, bid_tdata_o=0, bid_has_data_o=0, level_o=0, pkt_count_o=0. RAM contents are not reset.
REQ-026 SHALL discard any in-flight packet on mid-operation reset; s_tready rises on the first cycle after release.

Structure
REQ-027 SHALL keep MAX_PACKET high-speed/full-speed values (512/64) as constants in the shared USB definitions header used by the xfer blocks.
REQ-028 SHALL instantiate one sub-module, usb_fifo_ram: a simple dual-port 9-bit-wide RAM with 1-cycle registered read.
REQ-029 SHALL total 120-400 lines of RTL excluding the RAM.

Verification
REQ-030 SHALL write 10 bytes 0x00..0x09 with tlast on 0x09 -> bid_tvalid_o rises 2 cycles later, 10 bytes read with tlast on 0x09, pkt_count returns to 0.
REQ-031 SHALL write 600 bytes without tlast, MAX_PACKET=512 -> first packet is 512 bytes with forced tlast, has_data=1, remaining 88 bytes stay invisible until tlast.
REQ-032 SHALL fill with DEPTH_LOG2=4 (16 bytes) with bid_tready_i=0 -> s_tready=0 at level 16; one read -> s_tready=1 next cycle.
REQ-033 SHALL end input packet A and output packet B's last byte on the same cycle -> pkt_count unchanged, level unchanged.
REQ-034 SHALL stream 5000 random-length packets with random tready/tvalid -> output byte stream and boundaries match a scoreboard across pointer wrap.
REQ-035 SHALL pulse rst_n low mid-packet -> all outputs at reset values; next packet of 3 bytes is delivered intact.
